// File: rtl/fifo_ctrl.sv
// Pointer, flag and handshake controller for the UART FIFO storage array.
// Drives storage write/read enables and binary pointers; derives flags from the registered pointers.
module fifo_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter int PTR_WIDTH     = 4,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 mem_w_en,
  output logic                 mem_r_en,
  output logic [PTR_WIDTH-1:0] b_wptr,
  output logic [PTR_WIDTH-1:0] b_rptr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH-1:0] count,
  output logic                 rd_valid,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [PTR_WIDTH-1:0] cnt;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 full_w, empty_w;
  logic                 wr_ok, rd_ok;

  // Flags depend only on registered pointers; the wrap bit separates full from empty.
  always_comb begin
    empty_w = (wptr_q == rptr_q);
    full_w  = (wptr_q[PTR_WIDTH-1] != rptr_q[PTR_WIDTH-1]) &&
              (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    cnt     = wptr_q - rptr_q;
  end

  always_comb begin
    wr_ok       = push & ~full_w & ~flush & ~rst;
    rd_ok       = pop & ~empty_w & ~flush & ~rst;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_valid_d  = rd_ok;
    overflow_d  = (overflow_q & ~clr_err) | (push & full_w & ~flush);
    underflow_d = (underflow_q & ~clr_err) | (pop & empty_w & ~flush);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign mem_w_en     = wr_ok;
  assign mem_r_en     = rd_ok;
  assign b_wptr       = wptr_q;
  assign b_rptr       = rptr_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = cnt;
  assign almost_full  = (cnt >= PTR_WIDTH'(AFULL_THRESH));
  assign almost_empty = (cnt <= PTR_WIDTH'(AEMPTY_THRESH));
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: behavioural model plus a storage model whose
// read data is scoreboarded against the write order.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, push, pop, flush, clr_err;
  logic       mem_w_en, mem_r_en, full, empty, almost_full, almost_empty;
  logic       rd_valid, overflow, underflow;
  logic [3:0] b_wptr, b_rptr, count;

  fifo_ctrl #(
    .FIFO_DEPTH   (8),
    .PTR_WIDTH    (4),
    .AFULL_THRESH (6),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .clr_err     (clr_err),
    .mem_w_en    (mem_w_en),
    .mem_r_en    (mem_r_en),
    .b_wptr      (b_wptr),
    .b_rptr      (b_rptr),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .rd_valid    (rd_valid),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model state
  int   m_cnt = 0, m_wp = 0, m_rp = 0;
  bit   m_ov = 0, m_un = 0, m_rv = 0;
  bit   e_wr, e_rd;
  bit   a_r, a_p, a_q, a_f, a_c;
  logic [7:0] wdata = 8'd0;
  logic [7:0] sb[$];

  // Storage array with registered read port, driven by the DUT's enables and pointers
  logic [7:0] mem [8];
  logic [7:0] dout;
  always @(posedge clk) begin
    if (mem_w_en === 1'b1) mem[b_wptr[2:0]] <= wdata;
    if (mem_r_en === 1'b1) dout <= mem[b_rptr[2:0]];
  end

  always @(posedge clk) begin
    logic [7:0] exp_d;
    #2;
    if (rd_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL rd_data: got %h with rd_valid, want no read (scoreboard empty)", dout);
      end else begin
        exp_d = sb.pop_front();
        if (dout !== exp_d) $display("FAIL rd_data: got %h want %h", dout, exp_d);
        else passed++;
      end
    end
  end

  task automatic apply(input bit r, input bit p, input bit q, input bit f, input bit c);
    @(negedge clk);
    wdata   = wdata + 8'd1;
    rst     = r;
    push    = p;
    pop     = q;
    flush   = f;
    clr_err = c;
    a_r = r; a_p = p; a_q = q; a_f = f; a_c = c;
    e_wr = !r && p && !f && (m_cnt < 8);
    e_rd = !r && q && !f && (m_cnt > 0);
    if (e_wr) sb.push_back(wdata);
    #1;
  endtask

  task automatic tick();
    bit nov, nun;
    @(posedge clk);
    #1;
    if (a_r) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0; m_rv = 0;
      sb.delete();
    end else if (a_f) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_rv = 0;
      m_ov = m_ov && !a_c;
      m_un = m_un && !a_c;
      sb.delete();
    end else begin
      nov = (a_p && m_cnt == 8) || (m_ov && !a_c);
      nun = (a_q && m_cnt == 0) || (m_un && !a_c);
      m_ov = nov;
      m_un = nun;
      if (e_wr) begin m_wp = (m_wp + 1) % 16; m_cnt++; end
      if (e_rd) begin m_rp = (m_rp + 1) % 16; m_cnt--; end
      m_rv = e_rd;
    end
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 0, 0);
    total++;
    if ({mem_w_en, mem_r_en} !== 2'b00) $display("FAIL reset_en: got %b want 00", {mem_w_en, mem_r_en});
    else passed++;
    tick();
    total++;
    if ({b_wptr, b_rptr, count} !== 12'h000)
      $display("FAIL reset_ptrs: got %h want 000", {b_wptr, b_rptr, count});
    else passed++;
    total++;
    if ({full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !== 7'b0101000)
      $display("FAIL reset_flags: got %b want 0101000",
               {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow});
    else passed++;
    apply(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, 0, 0);
      total++;
      if (mem_w_en !== 1'b1) $display("FAIL fill_wen[%0d]: got %b want 1", i, mem_w_en);
      else passed++;
      tick();
      total++;
      if (count !== 4'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      else passed++;
      total++;
      if ({full, empty, almost_full} !== {i == 7, 1'b0, i >= 5})
        $display("FAIL fill_flags[%0d]: got %b want %b", i, {full, empty, almost_full},
                 {i == 7, 1'b0, i >= 5});
      else passed++;
    end
    total++;
    if (b_wptr !== 4'b1000) $display("FAIL fill_wptr: got %b want 1000", b_wptr);
    else passed++;
  endtask

  task automatic test_overflow();
    apply(0, 1, 0, 0, 0);
    total++;
    if (mem_w_en !== 1'b0) $display("FAIL ovf_wen: got %b want 0", mem_w_en);
    else passed++;
    tick();
    total++;
    if ({b_wptr, overflow} !== {4'b1000, 1'b1}) $display("FAIL ovf_set: got %b want 10001", {b_wptr, overflow});
    else passed++;
    apply(0, 0, 0, 0, 0);
    tick();
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else passed++;
    apply(0, 0, 0, 0, 1);
    tick();
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 1, 0, 0);
      total++;
      if (mem_r_en !== 1'b1) $display("FAIL drain_ren[%0d]: got %b want 1", i, mem_r_en);
      else passed++;
      tick();
      total++;
      if (count !== 4'(7 - i)) $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 7 - i);
      else passed++;
      total++;
      if ({rd_valid, almost_empty, empty} !== {1'b1, (7 - i) <= 2, i == 7})
        $display("FAIL drain_flags[%0d]: got %b want %b", i, {rd_valid, almost_empty, empty},
                 {1'b1, (7 - i) <= 2, i == 7});
      else passed++;
    end
    apply(0, 0, 1, 0, 0);
    total++;
    if (mem_r_en !== 1'b0) $display("FAIL drain_ren_empty: got %b want 0", mem_r_en);
    else passed++;
    tick();
    total++;
    if ({underflow, rd_valid} !== 2'b10) $display("FAIL drain_underflow: got %b want 10", {underflow, rd_valid});
    else passed++;
    apply(0, 0, 0, 0, 1);
    tick();
    total++;
    if (underflow !== 1'b0) $display("FAIL unf_clear: got %b want 0", underflow);
    else passed++;
  endtask

  task automatic test_empty_push_pop();
    apply(0, 1, 1, 0, 0);
    total++;
    if ({mem_w_en, mem_r_en} !== 2'b10) $display("FAIL epp_en: got %b want 10", {mem_w_en, mem_r_en});
    else passed++;
    tick();
    total++;
    if ({underflow, count, rd_valid} !== {1'b1, 4'd1, 1'b0})
      $display("FAIL epp_state: got %b want 100010", {underflow, count, rd_valid});
    else passed++;
    apply(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_back_to_back();
    bit saw_w = 0, saw_r = 0;
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0);
      tick();
    end
    total++;
    if (count !== 4'd4) $display("FAIL b2b_start: got %0d want 4", count);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 1, 0, 0);
      total++;
      if ({mem_w_en, mem_r_en} !== 2'b11) $display("FAIL b2b_en[%0d]: got %b want 11", i, {mem_w_en, mem_r_en});
      else passed++;
      tick();
      total++;
      if ({count, full, empty, rd_valid} !== {4'd4, 1'b0, 1'b0, 1'b1})
        $display("FAIL b2b_state[%0d]: got %b want 0100001", i, {count, full, empty, rd_valid});
      else passed++;
      total++;
      if ({b_wptr, b_rptr} !== {4'(m_wp), 4'(m_rp)})
        $display("FAIL b2b_ptrs[%0d]: got %h want %h", i, {b_wptr, b_rptr}, {4'(m_wp), 4'(m_rp)});
      else passed++;
      if (b_wptr === 4'd0) saw_w = 1;
      if (b_rptr === 4'd0) saw_r = 1;
    end
    total++;
    if ({saw_w, saw_r} !== 2'b11) $display("FAIL b2b_wrap: got %b want 11", {saw_w, saw_r});
    else passed++;
  endtask

  task automatic test_flush();
    apply(0, 1, 0, 0, 0);
    tick();
    apply(0, 1, 1, 0, 0);
    tick();
    total++;
    if ({count, rd_valid} !== {4'd5, 1'b1}) $display("FAIL flush_pre: got %b want 01011", {count, rd_valid});
    else passed++;
    apply(0, 1, 1, 1, 0);
    total++;
    if ({mem_w_en, mem_r_en} !== 2'b00) $display("FAIL flush_en: got %b want 00", {mem_w_en, mem_r_en});
    else passed++;
    tick();
    total++;
    if ({count, b_wptr, b_rptr} !== 12'h000) $display("FAIL flush_ptrs: got %h want 000", {count, b_wptr, b_rptr});
    else passed++;
    total++;
    if ({empty, rd_valid, underflow, overflow} !== 4'b1000)
      $display("FAIL flush_flags: got %b want 1000", {empty, rd_valid, underflow, overflow});
    else passed++;
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 300; i++) begin
      bias = (i < 100) ? 80 : (i < 200) ? 20 : 50;
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
      total++;
      if ({mem_w_en, mem_r_en} !== {e_wr, e_rd})
        $display("FAIL rnd_en[%0d]: got %b want %b", i, {mem_w_en, mem_r_en}, {e_wr, e_rd});
      else passed++;
      tick();
      total++;
      if ({count, b_wptr, b_rptr} !== {4'(m_cnt), 4'(m_wp), 4'(m_rp)})
        $display("FAIL rnd_ptrs[%0d]: got %h want %h", i, {count, b_wptr, b_rptr},
                 {4'(m_cnt), 4'(m_wp), 4'(m_rp)});
      else passed++;
      total++;
      if ({full, empty, almost_full, almost_empty} !== {m_cnt == 8, m_cnt == 0, m_cnt >= 6, m_cnt <= 2})
        $display("FAIL rnd_flags[%0d]: got %b want %b", i, {full, empty, almost_full, almost_empty},
                 {m_cnt == 8, m_cnt == 0, m_cnt >= 6, m_cnt <= 2});
      else passed++;
      total++;
      if ({rd_valid, overflow, underflow} !== {m_rv, m_ov, m_un})
        $display("FAIL rnd_status[%0d]: got %b want %b", i, {rd_valid, overflow, underflow}, {m_rv, m_ov, m_un});
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_push_pop();
    test_back_to_back();
    test_flush();
    test_random();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0);
      tick();
    end
    test_reset();
    #20;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Single-clock pointer, flag and handshake controller for the UART FIFO storage array (dual-port register file with registered read port). It accepts push/pop requests from the UART TX/RX datapath and drives the storage write enable, read enable and binary write/read pointers. It also produces full/empty/almost flags, an occupancy count, a read-data-valid strobe aligned to the storage's registered output, and sticky overflow/underflow error flags.

## Interface
- FIFO_DEPTH, 8: number of storage entries; power of two, ≥ 2
- PTR_WIDTH, 4: pointer width = log2(FIFO_DEPTH)+1 (MSB is the wrap bit)
- AFULL_THRESH, 6: almost_full asserts when count ≥ this value
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ this value

- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- push  in  1  write request from producer (data goes directly to storage)
- pop  in  1  read request from consumer
- flush  in  1  synchronous clear of FIFO contents
- clr_err  in  1  clears overflow/underflow
- mem_w_en  out  1  storage write enable
- mem_r_en  out  1  storage read enable
- b_wptr  out  PTR_WIDTH  write pointer; storage uses low log2(FIFO_DEPTH) bits
- b_rptr  out  PTR_WIDTH  read pointer; storage uses low log2(FIFO_DEPTH) bits
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  PTR_WIDTH  occupancy, 0..FIFO_DEPTH
- rd_valid  out  1  storage data_out valid this cycle
- overflow  out  1  sticky: push while full
- underflow  out  1  sticky: pop while empty

## Operation
- Write acceptance: wr_ok = push & !full & !flush & !rst. mem_w_en = wr_ok (combinational). On wr_ok, b_wptr increments by 1 modulo 2^PTR_WIDTH.
- Read acceptance: rd_ok = pop & !empty & !flush & !rst. mem_r_en = rd_ok (combinational). On rd_ok, b_rptr increments by 1 modulo 2^PTR_WIDTH.
- Flags and count are combinational from the registered pointers only. They never depend on the current push/pop.
  - empty = (b_wptr == b_rptr)
  - full = MSBs differ and low bits equal
  - count = (b_wptr − b_rptr) mod 2^PTR_WIDTH
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: pop accepted, push rejected and overflow set.
  - Empty: push accepted, pop rejected and underflow set. Data is not bypassed.
- Error flags:
  - overflow sets on push & full & !flush.
  - underflow sets on pop & empty & !flush.
  - Both flags are cleared by clr_err. Set wins over clr_err in the same cycle.
  - flush does not clear them.
- flush:
  - Next cycle: b_wptr = b_rptr = 0, rd_valid = 0.
  - Same cycle: push/pop ignored and not counted as errors.
- rd_valid is registered: rd_valid = rd_ok from the previous cycle. This aligns it with the storage's registered data_out.

## Timing
- Reset (rst high at posedge) forces:
  - b_wptr = b_rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - rd_valid = 0, overflow = 0, underflow = 0
- mem_w_en and mem_r_en are 0 while rst is high.
- Reset mid-operation discards contents; there is no drain.
- Push→flag latency: flags and count reflect an accepted push in the cycle after the push edge. Same for pop.
- Pop→data latency: 1 cycle. rd_valid is high exactly in the cycle after mem_r_en.
- Throughput: one push and one pop per cycle, sustained.
- Pointer wrap: after 2^PTR_WIDTH increments a pointer returns to 0. Flags stay correct across wrap because the MSB distinguishes full from empty.
- Priority per cycle: rst > flush > push/pop.

## Test plan
- Reset, then 8 consecutive pushes: count steps 0→8. almost_full rises after the 6th push, full after the 8th. b_wptr = 8 (4'b1000) and empty = 0.
- Full FIFO, push=1 for 1 cycle: mem_w_en = 0, b_wptr unchanged, overflow = 1 and remains 1. Then clr_err=1 for one cycle: overflow = 0 next cycle.
- Empty FIFO, push=pop=1 for 1 cycle: mem_w_en = 1, mem_r_en = 0, underflow = 1, count = 1 next cycle, rd_valid stays 0.
- Count 4, push=pop=1 for 20 cycles: count stays 4 throughout. Both pointers wrap past 15→0. rd_valid is high every cycle from the 2nd cycle on. full and empty never assert.
- Count 5 with pop=1, assert flush for 1 cycle: next cycle count = 0, empty = 1, rd_valid = 0, both pointers 0. underflow is not set.
- Drain 8 entries with continuous pop: mem_r_en for 8 cycles, rd_valid for 8 cycles lagging by 1. almost_empty rises when count reaches 2, empty when count reaches 0. A 9th pop sets underflow.
